// File: rtl/operand_fetch_arbiter.sv
// Two-requester operand fetch arbiter in front of a registered-read operand memory.
// Define OPFETCH_ROUND_ROBIN_EN for round-robin tie-breaking; the default is fixed priority to requester 0.
module operand_fetch_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                win_q, win_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win_sel;
`ifdef OPFETCH_ROUND_ROBIN_EN
  logic                last_q, last_d;
`endif

  // Winner selection, only consulted in IDLE with at least one request high.
  always_comb begin
`ifdef OPFETCH_ROUND_ROBIN_EN
    if (req0 && req1) win_sel = ~last_q;
    else              win_sel = ~req0;
`else
    win_sel = ~req0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      win_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef OPFETCH_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      win_q     <= win_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef OPFETCH_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    win_d   = win_q;
`ifdef OPFETCH_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ISSUE;
          addr_d  = win_sel ? addr1 : addr0;
          win_d   = win_sel;
`ifdef OPFETCH_ROUND_ROBIN_EN
          last_d  = win_sel;
`endif
        end
      end
      ISSUE:   state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory data arrives during DATA; capture it for the latched winner only.
  always_comb begin
    rvalid0_d = (state_q == DATA) && !win_q;
    rvalid1_d = (state_q == DATA) &&  win_q;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end

  always_comb begin
    gnt0     = (state_q == ISSUE) && !win_q;
    gnt1     = (state_q == ISSUE) &&  win_q;
    busy     = (state_q != IDLE);
    mem_addr = (state_q == ISSUE) ? addr_q : '0;
    rvalid0  = rvalid0_q;
    rvalid1  = rvalid1_q;
    rdata0   = rdata0_q;
    rdata1   = rdata1_q;
  end

endmodule

// File: tb/tb_operand_fetch_arbiter.sv
// Bench for operand_fetch_arbiter: directed scenarios then random traffic, checked each cycle
// against a transaction schedule model (grant at +1, data at +3, one read per 3 cycles).
module tb_operand_fetch_arbiter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int MAXC = 800;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DATA_W-1:0] rdata0, rdata1, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  operand_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:7];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Expected per-cycle outputs; -1 means no requester.
  int                exp_gnt   [0:MAXC+3];
  int                exp_rv    [0:MAXC+3];
  logic [DATA_W-1:0] exp_rd    [0:MAXC+3];
  logic [ADDR_W-1:0] exp_maddr [0:MAXC+3];
  bit                exp_busy  [0:MAXC+3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_free = 0;
  int last_served = 1;
  bit rst_prev = 1'b1;
  bit seen_g0, seen_g1;
  logic [DATA_W-1:0] er0, er1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r0, input int a0, input bit r1, input int a1, input bit rst);
    int w;
    int a;
    req0  = r0;
    addr0 = ADDR_W'(a0);
    req1  = r1;
    addr1 = ADDR_W'(a1);
    reset = rst;
    @(negedge clk);
    if (rst_prev) begin
      er0 = '0;
      er1 = '0;
    end
    if (exp_rv[cyc] == 0) er0 = exp_rd[cyc];
    if (exp_rv[cyc] == 1) er1 = exp_rd[cyc];
    check("gnt0",     32'(gnt0),     32'(exp_gnt[cyc] == 0));
    check("gnt1",     32'(gnt1),     32'(exp_gnt[cyc] == 1));
    check("rvalid0",  32'(rvalid0),  32'(exp_rv[cyc] == 0));
    check("rvalid1",  32'(rvalid1),  32'(exp_rv[cyc] == 1));
    check("rdata0",   32'(rdata0),   32'(er0));
    check("rdata1",   32'(rdata1),   32'(er1));
    check("mem_addr", 32'(mem_addr), 32'(exp_maddr[cyc]));
    check("busy",     32'(busy),     32'(exp_busy[cyc]));
    seen_g0 = gnt0;
    seen_g1 = gnt1;
    rst_prev = rst;
    if (rst) begin
      for (int j = cyc + 1; j <= cyc + 3; j++) begin
        exp_gnt[j] = -1; exp_rv[j] = -1; exp_busy[j] = 1'b0; exp_maddr[j] = '0;
      end
      next_free = cyc + 1;
      last_served = 1;
    end else if (cyc >= next_free && (r0 || r1)) begin
`ifdef OPFETCH_ROUND_ROBIN_EN
      if (r0 && r1) w = 1 - last_served;
      else          w = r0 ? 0 : 1;
`else
      w = r0 ? 0 : 1;
`endif
      a = (w == 0) ? a0 : a1;
      exp_gnt[cyc+1]   = w;
      exp_maddr[cyc+1] = ADDR_W'(a);
      exp_busy[cyc+1]  = 1'b1;
      exp_busy[cyc+2]  = 1'b1;
      exp_rv[cyc+3]    = w;
      exp_rd[cyc+3]    = mem[a];
      next_free = cyc + 3;
      last_served = w;
    end
    @(posedge clk);
    #1;
    if (cyc < MAXC) cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  bit r0, r1;
  int a0, a1;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = DATA_W'($urandom);
    mem[0] = 8'hF0; mem[1] = 8'h4E; mem[4] = 8'hEF; mem[7] = 8'h0B;
    for (int j = 0; j <= MAXC + 3; j++) begin
      exp_gnt[j] = -1; exp_rv[j] = -1; exp_rd[j] = '0; exp_maddr[j] = '0; exp_busy[j] = 1'b0;
    end
    er0 = '0; er1 = '0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the DATA cycle discards requester 1's read.
    step(0, 0, 1, 7, 0);
    step(0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 1);
    idle(3);
    // Single read of address 1.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(3);
    // Address changed in the ISSUE cycle must not disturb the in-flight read.
    step(1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(3);
    // Contention: requester 0 first, requester 1 held until served.
    step(1, 4, 1, 7, 0);
    step(1, 4, 1, 7, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 1, 7, 0);
    idle(4);
    // Both held continuously: alternation under round robin, requester 0 only otherwise.
    for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 0);
    idle(4);

    r0 = 1'b0; r1 = 1'b0; a0 = 0; a1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!r0) begin
        r0 = ($urandom_range(0, 2) == 0);
        a0 = int'($urandom_range(0, 7));
      end else if (seen_g0) begin
        r0 = $urandom_range(0, 1) == 1;
        a0 = int'($urandom_range(0, 7));
      end
      if (!r1) begin
        r1 = ($urandom_range(0, 2) == 0);
        a1 = int'($urandom_range(0, 7));
      end else if (seen_g1) begin
        r1 = $urandom_range(0, 1) == 1;
        a1 = int'($urandom_range(0, 7));
      end
      step(r0, a0, r1, a1, $urandom_range(0, 59) == 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_arbiter.md
OPERAND_FETCH_ARBITER -- requirements
Module: operand_fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 3, operand memory address width (8 entries). The block SHALL implement it as specified.
REQ-002 Parameter DATA_W, default 8, operand word width. The block SHALL implement it as specified.
REQ-003 The block SHALL provide port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL provide, for requester 0, port req0, input, 1 bit: read request, held until gnt0.
REQ-006 The block SHALL provide, for requester 0, port addr0, input, ADDR_W bits: operand address, valid while req0 is high.
REQ-007 The block SHALL provide, for requester 0, port gnt0, output, 1 bit: one-cycle grant pulse.
REQ-008 The block SHALL provide, for requester 0, port rvalid0, output, 1 bit: one-cycle read-data-valid pulse.
REQ-009 The block SHALL provide, for requester 0, port rdata0, output, DATA_W bits: returned operand.
REQ-010 The block SHALL provide req1, addr1, gnt1, rvalid1 and rdata1 for requester 1, identical to REQ-005..REQ-009.
REQ-011 The block SHALL provide port mem_addr, output, ADDR_W bits, driving the registered-read operand memory.
REQ-012 The block SHALL provide port mem_rdata, input, DATA_W bits: memory output, valid one cycle after mem_addr is presented.
REQ-013 The block SHALL provide port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ISSUE, DATA.
REQ-015 In IDLE with any req high at a rising edge, the block SHALL select a winner, latch the winner's address and ID, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 In ISSUE, mem_addr SHALL equal the latched address, the winner's gnt SHALL be high for exactly this cycle, and the next state SHALL be DATA.
REQ-017 In DATA, the block SHALL register mem_rdata into the winner's rdata and assert the winner's rvalid in the following cycle; the next state SHALL be IDLE.
REQ-018 Latency SHALL be 3 cycles from the req-sampling edge to rvalid high. Throughput SHALL be one read per 3 cycles.
REQ-019 rvalid SHALL be a single-cycle pulse. rdata SHALL hold its last value until overwritten by that requester's next read.
REQ-020 The non-winning requester's outputs SHALL be unaffected by a read it did not win. A losing req that stays high SHALL be served in the next IDLE evaluation.
REQ-021 addr/req changes after the sampling edge SHALL NOT affect an in-flight read.
REQ-022 At most one gnt SHALL be high in any cycle, and at most one rvalid SHALL be high in any cycle.
REQ-023 In IDLE, mem_addr SHALL be 0.
REQ-024 A new request SHALL NOT be sampled in ISSUE or DATA. The cycle that rvalid is high is IDLE, so back-to-back requests are sampled there.

Reset
REQ-025 On reset, the state SHALL go to IDLE, and gnt0, gnt1, rvalid0, rvalid1 and busy SHALL be 0.
REQ-026 On reset, rdata0, rdata1 and mem_addr SHALL be 0.
REQ-027 On reset, the last-served pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-028 Reset asserted in ISSUE or DATA SHALL discard the in-flight read, and no rvalid SHALL be produced for it.

Configuration
REQ-029 When macro OPFETCH_ROUND_ROBIN_EN is defined, a tie SHALL be granted to the requester not last served, and the pointer SHALL update on each grant.
REQ-030 When OPFETCH_ROUND_ROBIN_EN is undefined, requester 0 SHALL always win a tie (fixed priority), and the pointer logic SHALL be absent.

Verification
(Memory model preloaded with 0:F0, 1:4E, 4:EF, 7:0B.)
REQ-031 Scenario: req0 with addr0=1 after reset -> gnt0 in cycle +1, mem_addr=1 in cycle +1, rvalid0 with rdata0=4E in cycle +3, busy high in cycles +1..+2.
REQ-032 Scenario: req0 (addr 4) and req1 (addr 7) held together -> rdata0=EF first, then rdata1=0B three cycles later, with no overlap of gnt or rvalid.
REQ-033 Scenario: ROUND_ROBIN_EN defined, both req held continuously with addr0=0 and addr1=1 -> grants alternate 0,1,0,1 and rdata values alternate F0,4E.
REQ-034 Scenario: ROUND_ROBIN_EN undefined, same stimulus as REQ-033 -> only gnt0 pulses and gnt1 is never high.
REQ-035 Scenario: req1 with addr1=7, reset pulsed in the DATA cycle -> no rvalid1, rdata1 stays 0, busy=0 in the cycle after reset.
REQ-036 Scenario: addr0 changed from 4 to 0 in the ISSUE cycle -> returned rdata0=EF.
